// File: rtl/wb4_to_pi1.sv
// wb4_to_pi1: Wishbone B4 pipelined slave -> PI1 master bridge.
//
// Wishbone requests go into a small in-order FIFO. The FIFO head is presented
// on PI1; each accepted request produces exactly one wb4_ack_o, in order,
// unless the Wishbone cycle is dropped first.
//
// Ports:
//   clk_i, rst_n        clock, asynchronous active-low reset
//   wb4_cyc_i/stb_i     Wishbone cycle / strobe
//   wb4_we_i            1 = write, 0 = read
//   wb4_addr_i          byte address
//   wb4_data_i/sel_i    write data / byte enables
//   wb4_stall_o         request not accepted this cycle (FIFO full)
//   wb4_ack_o           one-cycle completion strobe per request
//   wb4_data_o          read data, valid with wb4_ack_o on reads
//   pi1_op_o            0 = NOOP, 1 = WR, 2 = RD
//   pi1_addr_o          word address
//   pi1_data_o/sel_o    write data / byte enables
//   pi1_data_i          read data from PI1 slave
//   pi1_rdy_i           PI1 ready
//
// Handshakes: Wishbone accepts on cyc & stb & !stall. PI1 issues on an edge
// with op != NOOP & rdy; the issued request completes at the next edge with
// rdy high, which may coincide with the issue of the following request.
module wb4_to_pi1 #(
    parameter int ARCHBITSZ = 32,
    parameter int FIFODEPTH = 4
) (
    input  logic                                      clk_i,
    input  logic                                      rst_n,
    input  logic                                      wb4_cyc_i,
    input  logic                                      wb4_stb_i,
    input  logic                                      wb4_we_i,
    input  logic [ARCHBITSZ-1:0]                      wb4_addr_i,
    input  logic [ARCHBITSZ-1:0]                      wb4_data_i,
    input  logic [ARCHBITSZ/8-1:0]                    wb4_sel_i,
    output logic                                      wb4_stall_o,
    output logic                                      wb4_ack_o,
    output logic [ARCHBITSZ-1:0]                      wb4_data_o,
    output logic [1:0]                                pi1_op_o,
    output logic [ARCHBITSZ-$clog2(ARCHBITSZ/8)-1:0]  pi1_addr_o,
    output logic [ARCHBITSZ-1:0]                      pi1_data_o,
    input  logic [ARCHBITSZ-1:0]                      pi1_data_i,
    output logic [ARCHBITSZ/8-1:0]                    pi1_sel_o,
    input  logic                                      pi1_rdy_i
);

    localparam int SELW = ARCHBITSZ / 8;
    localparam int OFFW = $clog2(SELW);
    localparam int AW   = ARCHBITSZ - OFFW;
    localparam int PW   = $clog2(FIFODEPTH);

    localparam logic [1:0]  OP_NOOP  = 2'd0;
    localparam logic [1:0]  OP_WR    = 2'd1;
    localparam logic [1:0]  OP_RD    = 2'd2;
    localparam logic [PW:0] FULL_CNT = (PW + 1)'(FIFODEPTH);

    // FIFO storage (no reset needed: contents are only read while count != 0)
    logic             fifo_we_q   [FIFODEPTH];
    logic [AW-1:0]    fifo_addr_q [FIFODEPTH];
    logic [ARCHBITSZ-1:0] fifo_data_q [FIFODEPTH];
    logic [SELW-1:0]  fifo_sel_q  [FIFODEPTH];

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW:0]      count_q, count_d;
    logic             pend_q, pend_d;
    logic             pendwe_q, pendwe_d;
    logic             ack_q, ack_d;
    logic [ARCHBITSZ-1:0] rdata_q, rdata_d;

    // Last values presented on PI1, held while the FIFO is empty
    logic [AW-1:0]        last_addr_q;
    logic [ARCHBITSZ-1:0] last_data_q;
    logic [SELW-1:0]      last_sel_q;

    logic push, issue, complete, nempty;

    assign nempty   = (count_q != '0);
    assign push     = wb4_cyc_i & wb4_stb_i & ~wb4_stall_o;
    assign issue    = nempty & pi1_rdy_i;
    assign complete = pend_q & pi1_rdy_i;

    // Outputs: decodes of registered state only
    assign wb4_stall_o = (count_q == FULL_CNT);
    assign wb4_ack_o   = ack_q;
    assign wb4_data_o  = rdata_q;
    assign pi1_op_o    = nempty ? (fifo_we_q[rd_ptr_q] ? OP_WR : OP_RD) : OP_NOOP;
    assign pi1_addr_o  = nempty ? fifo_addr_q[rd_ptr_q] : last_addr_q;
    assign pi1_data_o  = nempty ? fifo_data_q[rd_ptr_q] : last_data_q;
    assign pi1_sel_o   = nempty ? fifo_sel_q[rd_ptr_q]  : last_sel_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (!wb4_cyc_i) begin
            // Abort: discard every unissued request
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push)  wr_ptr_d = wr_ptr_q + PW'(1);
            if (issue) rd_ptr_d = rd_ptr_q + PW'(1);
            case ({push, issue})
                2'b10:   count_d = count_q + (PW + 1)'(1);
                2'b01:   count_d = count_q - (PW + 1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_comb begin
        pend_d   = pend_q;
        pendwe_d = pendwe_q;
        ack_d    = 1'b0;
        rdata_d  = rdata_q;
        // A new issue on the completion edge keeps pend set for the new request
        if (issue) begin
            pend_d   = 1'b1;
            pendwe_d = fifo_we_q[rd_ptr_q];
        end else if (complete) begin
            pend_d = 1'b0;
        end
        if (complete) begin
            ack_d = wb4_cyc_i;
            if (!pendwe_q) rdata_d = pi1_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            pend_q      <= 1'b0;
            pendwe_q    <= 1'b0;
            ack_q       <= 1'b0;
            rdata_q     <= '0;
            last_addr_q <= '0;
            last_data_q <= '0;
            last_sel_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            pend_q   <= pend_d;
            pendwe_q <= pendwe_d;
            ack_q    <= ack_d;
            rdata_q  <= rdata_d;
            if (nempty) begin
                last_addr_q <= fifo_addr_q[rd_ptr_q];
                last_data_q <= fifo_data_q[rd_ptr_q];
                last_sel_q  <= fifo_sel_q[rd_ptr_q];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_we_q[wr_ptr_q]   <= wb4_we_i;
            fifo_addr_q[wr_ptr_q] <= wb4_addr_i[ARCHBITSZ-1:OFFW];
            fifo_data_q[wr_ptr_q] <= wb4_data_i;
            fifo_sel_q[wr_ptr_q]  <= wb4_sel_i;
        end
    end

endmodule
